// File: rtl/mp_pkg.sv
// mp_pkg: shared micropipeline types and constants.
// Used by the sink here and by the future source-side block.
package mp_pkg;

    typedef enum logic [0:0] {
        WAIT_REQ = 1'b0,
        WAIT_RTZ = 1'b1
    } mp_state_e;

    localparam int unsigned MP_SYNC_STAGES = 2;

endpackage

// File: rtl/mp_sink_fifo.sv
// mp_sink_fifo: circular token buffer for the micropipeline sink.
// Ports: clk, reset (sync, active-low), push/push_data, pop,
//        full, empty, count (0..DEPTH), head (data at read pointer).
module mp_sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mp_sync_sink.sv
// mp_sync_sink: clocked end of the 4-phase bundled-data micropipeline.
// Ports: clk, reset (sync, active-low), req_i/data_i/ack_o (handshake),
//        out_valid/out_ready/out_data (consumer side), count (occupancy).
module mp_sync_sink
    import mp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = MP_SYNC_STAGES,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ack_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    mp_state_e              state;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    // data_i is bundled: it is stable by the time req_s is seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Full uses registered occupancy: a same-cycle pop frees a
    // slot only for the following cycle.
    assign push      = (state == WAIT_REQ) & req_s & ~full;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= WAIT_REQ;
            ack_o <= 1'b0;
        end else begin
            unique case (state)
                WAIT_REQ: begin
                    if (push) begin
                        state <= WAIT_RTZ;
                        ack_o <= 1'b1;
                    end
                end
                WAIT_RTZ: begin
                    if (!req_s) begin
                        state <= WAIT_REQ;
                        ack_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    mp_sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (data_i),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (out_data)
    );

endmodule

// File: tb/tb_mp_sync_sink.sv
// tb_mp_sync_sink: randomized and directed bench for mp_sync_sink.
// Reference is a token queue plus a req delay line, checked every cycle.
module tb_mp_sync_sink;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             ack_o;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    int errors = 0;
    int checks = 0;

    mp_sync_sink #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // Reference: tokens in a queue, req seen SYNC edges late,
    // one token accepted per req high/low cycle, full blocks accept.
    logic [WIDTH-1:0] mq[$];
    bit               dq[$];
    bit               m_ack = 1'b0;
    bit               armed = 1'b0;
    int               maxcnt = 0;
    logic [WIDTH-1:0] got[$];

    always @(posedge clk) begin
        bit rs;
        bit psh;
        bit pp;
        if (!reset) begin
            mq.delete();
            dq.delete();
            for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
            m_ack = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            rs = dq.pop_front();
            dq.push_back(req_i);
            psh = !m_ack && rs && (mq.size() < DEPTH);
            pp  = (mq.size() > 0) && out_ready;
            if (pp) void'(mq.pop_front());
            if (psh) mq.push_back(data_i);
            if (psh) m_ack = 1'b1;
            else if (m_ack && !rs) m_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("ack_o", 32'(ack_o), 32'(m_ack));
            chk("count", 32'(count), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0 && out_valid === 1'b1)
                chk("out_data", 32'(out_data), 32'(mq[0]));
            if (int'(count) > maxcnt) maxcnt = int'(count);
            if (out_valid === 1'b1 && out_ready)
                got.push_back(out_data);
        end
    end

    bit rnd_ready = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(logic v, int budget, string nm,
                            output int n);
        n = 0;
        while (ack_o !== v && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ack_o !== v) begin
            checks++;
            errors++;
            $display("FAIL %s timeout ack_o=%b want=%b", nm, ack_o, v);
        end
    endtask

    task automatic send(logic [WIDTH-1:0] d);
        int n;
        data_i = d;
        req_i  = 1'b1;
        wait_ack(1'b1, 300, "send_rise", n);
        step(1);
        req_i = 1'b0;
        wait_ack(1'b0, 300, "send_fall", n);
    endtask

    initial begin
        int n;
        // Reset state
        step(3);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        reset = 1'b1;
        step(2);

        // Single token
        data_i = 8'hA5;
        req_i  = 1'b1;
        wait_ack(1'b1, 50, "single_rise", n);
        chk("single_rise_le3", 32'(n <= 3), 32'h1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_cnt", 32'(count), 32'h1);
        req_i = 1'b0;
        wait_ack(1'b0, 50, "single_fall", n);
        chk("single_fall_le3", 32'(n <= 3), 32'h1);
        step(4);
        chk("single_hold", 32'(count), 32'h1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("single_pop", 32'(count), 32'h0);

        // Back-pressure fill
        got.delete();
        for (int i = 1; i <= 4; i++) send(WIDTH'(i));
        chk("bp_full", 32'(count), 32'h4);
        data_i = 8'h05;
        req_i  = 1'b1;
        step(12);
        chk("bp_stall_ack", 32'(ack_o), 32'h0);
        chk("bp_stall_cnt", 32'(count), 32'h4);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        wait_ack(1'b1, 20, "bp_fifth", n);
        chk("bp_cnt4", 32'(count), 32'h4);
        req_i = 1'b0;
        wait_ack(1'b0, 20, "bp_fall", n);
        out_ready = 1'b1;
        step(6);
        out_ready = 1'b0;
        chk("bp_npop", 32'(got.size()), 32'h5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk("bp_order", 32'(got[i]), 32'(i + 1));

        // Pointer wrap with a ready consumer
        got.delete();
        maxcnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(WIDTH'(8'h10 + i));
        step(3);
        chk("wrap_n", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk("wrap_order", 32'(got[i]), 32'(8'h10 + i));
        chk("wrap_max", 32'(maxcnt <= 1), 32'h1);
        out_ready = 1'b0;

        // Push and pop on the same edge
        got.delete();
        send(8'h21);
        send(8'h22);
        chk("sim_cnt2", 32'(count), 32'h2);
        data_i = 8'h33;
        req_i  = 1'b1;
        step(2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("sim_ack", 32'(ack_o), 32'h1);
        chk("sim_cnt", 32'(count), 32'h2);
        req_i = 1'b0;
        wait_ack(1'b0, 20, "sim_fall", n);
        out_ready = 1'b1;
        step(4);
        out_ready = 1'b0;
        chk("sim_n", 32'(got.size()), 32'h3);
        if (got.size() == 3) begin
            chk("sim_o0", 32'(got[0]), 32'h21);
            chk("sim_o1", 32'(got[1]), 32'h22);
            chk("sim_o2", 32'(got[2]), 32'h33);
        end

        // Reset in the middle of a handshake
        send(8'h41);
        send(8'h42);
        data_i = 8'h43;
        req_i  = 1'b1;
        wait_ack(1'b1, 20, "rmid_rise", n);
        chk("rmid_cnt3", 32'(count), 32'h3);
        reset = 1'b0;
        req_i = 1'b0;
        step(1);
        chk("rmid_ack", 32'(ack_o), 32'h0);
        chk("rmid_cnt", 32'(count), 32'h0);
        chk("rmid_valid", 32'(out_valid), 32'h0);
        step(2);
        reset = 1'b1;
        step(10);
        chk("rmid_quiet", 32'(count), 32'h0);

        // Duplicate guard
        data_i = 8'h55;
        req_i  = 1'b1;
        wait_ack(1'b1, 20, "dup_rise", n);
        step(20);
        chk("dup_cnt", 32'(count), 32'h1);
        chk("dup_ack", 32'(ack_o), 32'h1);
        req_i = 1'b0;
        wait_ack(1'b0, 20, "dup_fall", n);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;

        // Random traffic
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3));
            send(WIDTH'($urandom));
        end
        rnd_ready = 1'b0;
        step(1);
        out_ready = 1'b1;
        step(12);
        chk("final_empty", 32'(count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
